// File: rtl/vga_text_writer_m.sv
// Write side of the 80x60 text-mode character memory: turns a byte stream into
// byte-enabled word writes, tracks the cursor and blanks rows/screen as needed.
module vga_text_writer_m #(
  parameter int COLS          = 80,
  parameter int ROWS          = 60,
  parameter int WORDS_PER_ROW = COLS / 2
) (
  input  logic        i_clk_25MHz,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_char,
  input  logic [7:0]  i_attr,
  output logic [3:0]  o_mem_we,
  output logic [11:0] o_mem_waddr,
  output logic [31:0] o_mem_wdata,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row
);

  localparam logic [11:0] WPR       = 12'(WORDS_PER_ROW);
  localparam logic [11:0] ALL_WORDS = 12'(ROWS * WORDS_PER_ROW);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [7:0]  fill_attr_q, fill_attr_d;
  logic [11:0] k_q, k_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [11:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        char_wr;
  logic [6:0]  char_col;
  logic [7:0]  char_code;
  logic [5:0]  next_row;

  function automatic logic [11:0] row_base(input logic [5:0] r);
    return {6'b0, r} * WPR;
  endfunction

  function automatic logic [31:0] fill_word(input logic [7:0] a);
    return {a, 8'h20, a, 8'h20};
  endfunction

  assign next_row = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    fill_attr_d = fill_attr_q;
    k_d         = k_q;
    mem_we_d    = 4'h0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    char_wr     = 1'b0;
    char_col    = col_q;
    char_code   = i_char;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          fill_attr_d = i_attr;
          case (i_char)
            8'h0D: col_d = 7'd0;
            8'h0A: begin
              // The first blanking word goes out with the acceptance slot.
              col_d       = 7'd0;
              row_d       = next_row;
              state_d     = CLEAR_ROW;
              mem_we_d    = 4'hF;
              mem_waddr_d = row_base(next_row);
              mem_wdata_d = fill_word(i_attr);
              k_d         = 12'd1;
            end
            8'h08: begin
              if (col_q != 7'd0) begin
                col_d     = col_q - 7'd1;
                char_wr   = 1'b1;
                char_col  = col_q - 7'd1;
                char_code = 8'h20;
              end
            end
            8'h0C: begin
              col_d       = 7'd0;
              row_d       = 6'd0;
              state_d     = CLEAR_ALL;
              mem_we_d    = 4'hF;
              mem_waddr_d = 12'd0;
              mem_wdata_d = fill_word(i_attr);
              k_d         = 12'd1;
            end
            default: begin
              char_wr = 1'b1;
              if (col_q == LAST_COL) begin
                // Character write owns this slot, so the row clear starts at word 0 next cycle.
                col_d   = 7'd0;
                row_d   = next_row;
                state_d = CLEAR_ROW;
                k_d     = 12'd0;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase
        end
      end
      CLEAR_ROW: begin
        if (k_q == WPR) begin
          state_d = IDLE;
        end else begin
          mem_we_d    = 4'hF;
          mem_waddr_d = row_base(row_q) + k_q;
          mem_wdata_d = fill_word(fill_attr_q);
          k_d         = k_q + 12'd1;
        end
      end
      CLEAR_ALL: begin
        if (k_q == ALL_WORDS) begin
          state_d = IDLE;
        end else begin
          mem_we_d    = 4'hF;
          mem_waddr_d = k_q;
          mem_wdata_d = fill_word(fill_attr_q);
          k_d         = k_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (char_wr) begin
      mem_waddr_d = row_base(row_q) + {6'b0, char_col[6:1]};
      if (char_col[0]) begin
        mem_we_d    = 4'b0011;
        mem_wdata_d = {16'h0, i_attr, char_code};
      end else begin
        mem_we_d    = 4'b1100;
        mem_wdata_d = {i_attr, char_code, 16'h0};
      end
    end
  end

  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      col_q       <= 7'd0;
      row_q       <= 6'd0;
      fill_attr_q <= 8'h00;
      k_q         <= 12'd0;
      mem_we_q    <= 4'h0;
      mem_waddr_q <= 12'd0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fill_attr_q <= fill_attr_d;
      k_q         <= k_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_mem_we     = mem_we_q;
  assign o_mem_waddr  = mem_waddr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_cursor_col = col_q;
  assign o_cursor_row = row_q;

endmodule

// File: tb/tb_vga_text_writer_m.sv
// Bench for vga_text_writer_m: directed scenarios plus a random byte stream
// compared against a screen-level reference model of the character writer.
module tb_vga_text_writer_m;

  localparam int NCOLS = 80;
  localparam int NROWS = 60;
  localparam int WPR   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_char = 8'h00;
  logic [7:0]  i_attr = 8'h00;
  logic        o_ready;
  logic [3:0]  o_mem_we;
  logic [11:0] o_mem_waddr;
  logic [31:0] o_mem_wdata;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;

  always #20 clk = ~clk;

  vga_text_writer_m dut (
    .i_clk_25MHz (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_char      (i_char),
    .i_attr      (i_attr),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_cursor_col(o_cursor_col),
    .o_cursor_row(o_cursor_row)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  exp_low, got_low, got_first, got_last;
  int  mcol = 0, mrow = 0;

  // Reference model: what one accepted byte should do to screen and cursor.
  function automatic void model_put(int col, int row, logic [7:0] ch, logic [7:0] at);
    wr_t w;
    w.a = 12'(row * WPR + col / 2);
    if (col % 2 == 0) begin
      w.we = 4'b1100;
      w.d  = {at, ch, 16'h0000};
    end else begin
      w.we = 4'b0011;
      w.d  = {16'h0000, at, ch};
    end
    exp_q.push_back(w);
  endfunction

  function automatic void model_clear(int first, int count, logic [7:0] at);
    wr_t w;
    for (int i = 0; i < count; i++) begin
      w.a  = 12'(first + i);
      w.we = 4'hF;
      w.d  = {at, 8'h20, at, 8'h20};
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_byte(logic [7:0] ch, logic [7:0] at);
    bit clr = 0;
    exp_q.delete();
    case (ch)
      8'h0D: mcol = 0;
      8'h0A: begin
        mcol = 0;
        mrow = (mrow + 1) % NROWS;
        model_clear(mrow * WPR, WPR, at);
        clr = 1;
      end
      8'h08: if (mcol > 0) begin
        mcol = mcol - 1;
        model_put(mcol, mrow, 8'h20, at);
      end
      8'h0C: begin
        mcol = 0;
        mrow = 0;
        model_clear(0, NROWS * WPR, at);
        clr = 1;
      end
      default: begin
        model_put(mcol, mrow, ch, at);
        if (mcol == NCOLS - 1) begin
          mcol = 0;
          mrow = (mrow + 1) % NROWS;
          model_clear(mrow * WPR, WPR, at);
          clr = 1;
        end else begin
          mcol = mcol + 1;
        end
      end
    endcase
    exp_low = clr ? exp_q.size() : 0;
  endfunction

  // Present one byte, then record every write and busy cycle until idle again.
  task automatic send(input logic [7:0] ch, input logic [7:0] at, input bit noise);
    model_byte(ch, at);
    @(negedge clk);
    i_valid = 1'b1;
    i_char  = ch;
    i_attr  = at;
    @(posedge clk);
    #1;
    i_valid = noise;
    got_q.delete();
    got_low = 0;
    got_first = -1;
    got_last = -1;
    for (int n = 0; n < 3000; n++) begin
      if (o_mem_we != 4'h0) begin
        got_q.push_back({o_mem_waddr, o_mem_we, o_mem_wdata});
        if (got_first < 0) got_first = n;
        got_last = n;
      end
      if (!o_ready) got_low++;
      if (o_ready && o_mem_we == 4'h0) begin
        i_valid = 1'b0;
        return;
      end
      if (noise) begin
        i_char = 8'($urandom);
        i_attr = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    checks++;
    failures++;
    $display("FAIL send_timeout char=%h still busy after 3000 cycles, required idle", ch);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_mem_we !== 4'h0) begin failures++; $display("FAIL rst_we got=%h exp=0", o_mem_we); end
    checks++; if (o_mem_waddr !== 12'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", o_mem_waddr); end
    checks++; if (o_mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", o_mem_wdata); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    mcol = 0;
    mrow = 0;
    @(posedge clk);
    #1;
    checks++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0) begin
      failures++; $display("FAIL rst_cursor got=(%0d,%0d) exp=(0,0)", o_cursor_col, o_cursor_row);
    end
    checks++; if (o_ready !== 1'b1 || o_mem_we !== 4'h0) begin
      failures++; $display("FAIL rst_idle got ready=%b we=%h exp ready=1 we=0", o_ready, o_mem_we);
    end
  endtask

  task automatic test_basic;
    send(8'h41, 8'h1F, 1'b0);
    checks++; if (got_q.size() !== 1 || got_first !== 0) begin
      failures++; $display("FAIL char_a_count got=%0d first=%0d exp=1 first=0", got_q.size(), got_first);
    end else begin
      checks++; if (got_q[0] !== {12'd0, 4'b1100, 32'h1F41_0000}) begin
        failures++; $display("FAIL char_a_write got=%h exp=%h", got_q[0], {12'd0, 4'b1100, 32'h1F41_0000});
      end
    end
    checks++; if (got_low !== 0 || o_cursor_col !== 7'd1 || o_cursor_row !== 6'd0) begin
      failures++; $display("FAIL char_a_state got low=%0d cur=(%0d,%0d) exp low=0 cur=(1,0)", got_low, o_cursor_col, o_cursor_row);
    end
    send(8'h42, 8'h2E, 1'b0);
    checks++; if (got_q.size() !== 1 || got_q[0] !== {12'd0, 4'b0011, 32'h0000_2E42}) begin
      failures++; $display("FAIL char_b_write got n=%0d w=%h exp n=1 w=%h", got_q.size(), got_q.size() ? got_q[0] : '0, {12'd0, 4'b0011, 32'h0000_2E42});
    end
    checks++; if (o_cursor_col !== 7'd2 || o_cursor_row !== 6'd0) begin
      failures++; $display("FAIL char_b_cursor got=(%0d,%0d) exp=(2,0)", o_cursor_col, o_cursor_row);
    end
  endtask

  task automatic test_line_feed;
    send(8'h0C, 8'h00, 1'b0);
    checks++; if (got_q.size() !== 2400 || got_low !== 2400) begin
      failures++; $display("FAIL ff_count got writes=%0d low=%0d exp 2400/2400", got_q.size(), got_low);
    end else begin
      checks++; if (got_q[2399].a !== 12'd2399 || got_q[0].a !== 12'd0) begin
        failures++; $display("FAIL ff_addr got first=%0d last=%0d exp 0/2399", got_q[0].a, got_q[2399].a);
      end
    end
    repeat (3) send(8'h0A, 8'h00, 1'b0);
    repeat (5) send(8'h61, 8'h07, 1'b0);
    send(8'h0A, 8'h07, 1'b0);
    checks++; if (got_q.size() !== 40 || got_low !== 40 || got_first !== 0 || got_last !== 39) begin
      failures++; $display("FAIL lf_count got writes=%0d low=%0d span=%0d..%0d exp 40/40 0..39", got_q.size(), got_low, got_first, got_last);
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_q[i] !== {12'(160 + i), 4'hF, 32'h0720_0720}) begin
          failures++; $display("FAIL lf_word%0d got=%h exp=%h", i, got_q[i], {12'(160 + i), 4'hF, 32'h0720_0720});
          break;
        end
      end
    end
    checks++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 6'd4) begin
      failures++; $display("FAIL lf_cursor got=(%0d,%0d) exp=(0,4)", o_cursor_col, o_cursor_row);
    end
  endtask

  task automatic test_wrap;
    send(8'h0C, 8'h00, 1'b0);
    repeat (59) send(8'h0A, 8'h00, 1'b0);
    repeat (79) send(8'h2A, 8'h11, 1'b0);
    checks++; if (o_cursor_col !== 7'd79 || o_cursor_row !== 6'd59) begin
      failures++; $display("FAIL wrap_setup got=(%0d,%0d) exp=(79,59)", o_cursor_col, o_cursor_row);
    end
    send(8'h5A, 8'h1F, 1'b0);
    checks++; if (got_q.size() !== 41 || got_low !== 41 || got_first !== 0 || got_last !== 40) begin
      failures++; $display("FAIL wrap_count got writes=%0d low=%0d span=%0d..%0d exp 41/41 0..40", got_q.size(), got_low, got_first, got_last);
    end else begin
      checks++; if (got_q[0] !== {12'd2399, 4'b0011, 32'h0000_1F5A}) begin
        failures++; $display("FAIL wrap_char got=%h exp=%h", got_q[0], {12'd2399, 4'b0011, 32'h0000_1F5A});
      end
      checks++; if (got_q[1] !== {12'd0, 4'hF, 32'h1F20_1F20} || got_q[40].a !== 12'd39) begin
        failures++; $display("FAIL wrap_clear got first=%h last_addr=%0d exp first=%h last_addr=39", got_q[1], got_q[40].a, {12'd0, 4'hF, 32'h1F20_1F20});
      end
    end
    checks++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0) begin
      failures++; $display("FAIL wrap_cursor got=(%0d,%0d) exp=(0,0)", o_cursor_col, o_cursor_row);
    end
  endtask

  task automatic test_backspace;
    repeat (10) send(8'h0A, 8'h00, 1'b0);
    send(8'h08, 8'h55, 1'b0);
    checks++; if (got_q.size() !== 0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd10) begin
      failures++; $display("FAIL bs_col0 got writes=%0d cur=(%0d,%0d) exp 0 writes cur=(0,10)", got_q.size(), o_cursor_col, o_cursor_row);
    end
    repeat (3) send(8'h78, 8'h33, 1'b0);
    send(8'h08, 8'h4A, 1'b0);
    checks++; if (got_q.size() !== 1 || got_q[0] !== {12'd401, 4'b1100, 32'h4A20_0000}) begin
      failures++; $display("FAIL bs_write got n=%0d w=%h exp n=1 w=%h", got_q.size(), got_q.size() ? got_q[0] : '0, {12'd401, 4'b1100, 32'h4A20_0000});
    end
    checks++; if (o_cursor_col !== 7'd2 || o_cursor_row !== 6'd10) begin
      failures++; $display("FAIL bs_cursor got=(%0d,%0d) exp=(2,10)", o_cursor_col, o_cursor_row);
    end
  endtask

  task automatic test_busy_ignore;
    int row0;
    row0 = mrow;
    send(8'h0A, 8'h6C, 1'b1);
    checks++; if (got_q.size() !== 40 || got_low !== 40) begin
      failures++; $display("FAIL busy_count got writes=%0d low=%0d exp 40/40", got_q.size(), got_low);
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL busy_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
    checks++; if (o_cursor_col !== 7'd0 || int'(o_cursor_row) !== (row0 + 1) % NROWS) begin
      failures++; $display("FAIL busy_cursor got=(%0d,%0d) exp=(0,%0d)", o_cursor_col, o_cursor_row, (row0 + 1) % NROWS);
    end
  endtask

  task automatic test_random;
    logic [7:0] ch;
    int r;
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 99);
      if (r < 8) ch = 8'h0A;
      else if (r < 11) ch = 8'h0D;
      else if (r < 16) ch = 8'h08;
      else if (r < 17) ch = 8'h0C;
      else ch = 8'($urandom);
      send(ch, 8'($urandom), 1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        failures++; $display("FAIL rnd%0d_count char=%h got=%0d exp=%0d", t, ch, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL rnd%0d_word%0d char=%h got=%h exp=%h", t, i, ch, got_q[i], exp_q[i]);
            break;
          end
        end
        if (exp_q.size() > 0) begin
          checks++;
          if (got_first !== 0 || got_last !== exp_q.size() - 1) begin
            failures++; $display("FAIL rnd%0d_timing got span=%0d..%0d exp 0..%0d", t, got_first, got_last, exp_q.size() - 1);
          end
        end
      end
      checks++;
      if (got_low !== exp_low) begin
        failures++; $display("FAIL rnd%0d_busy char=%h got=%0d exp=%0d", t, ch, got_low, exp_low);
      end
      checks++;
      if (int'(o_cursor_col) !== mcol || int'(o_cursor_row) !== mrow) begin
        failures++; $display("FAIL rnd%0d_cursor char=%h got=(%0d,%0d) exp=(%0d,%0d)", t, ch, o_cursor_col, o_cursor_row, mcol, mrow);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int cnt, extra_wr, extra_busy;
    repeat (7) send(8'h50, 8'h21, 1'b0);
    @(negedge clk);
    i_valid = 1'b1;
    i_char  = 8'h0C;
    i_attr  = 8'h33;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (o_mem_we != 4'h0) cnt++;
      if (cnt == 1000) break;
      @(posedge clk);
      #1;
    end
    checks++; if (cnt !== 1000 || o_mem_waddr !== 12'd999) begin
      failures++; $display("FAIL rstmid_progress got writes=%0d addr=%0d exp 1000 addr=999", cnt, o_mem_waddr);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (o_mem_we !== 4'h0) begin failures++; $display("FAIL rstmid_we got=%h exp=0", o_mem_we); end
    checks++; if (o_ready !== 1'b1 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0) begin
      failures++; $display("FAIL rstmid_state got ready=%b cur=(%0d,%0d) exp ready=1 cur=(0,0)", o_ready, o_cursor_col, o_cursor_row);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mcol = 0;
    mrow = 0;
    extra_wr = 0;
    extra_busy = 0;
    repeat (2500) begin
      @(posedge clk);
      #1;
      if (o_mem_we != 4'h0) extra_wr++;
      if (!o_ready) extra_busy++;
    end
    checks++; if (extra_wr !== 0 || extra_busy !== 0) begin
      failures++; $display("FAIL rstmid_after got writes=%0d busy=%0d exp 0/0", extra_wr, extra_busy);
    end
    send(8'h41, 8'h1F, 1'b0);
    checks++; if (got_q.size() !== 1 || got_q[0] !== {12'd0, 4'b1100, 32'h1F41_0000}) begin
      failures++; $display("FAIL rstmid_resume got n=%0d w=%h exp n=1 w=%h", got_q.size(), got_q.size() ? got_q[0] : '0, {12'd0, 4'b1100, 32'h1F41_0000});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_line_feed();
    test_wrap();
    test_backspace();
    test_busy_ignore();
    test_random();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_writer_m.md
Name: vga_text_writer_m

Overview:
- Character-stream front end for the text-mode VGA display; the write side of the 80x60 character memory that the VGA driver scans out.
- Accepts bytes over a valid/ready handshake and keeps a cursor.
- Turns printable bytes into byte-enabled word writes on the memory write port (we/waddr/wdata).
- Handles CR, LF, backspace and form-feed; clears rows on line advance and the whole screen on form-feed.

Parameters:
- COLS, 80: characters per row; must be even; 2 chars per 32-bit word.
- ROWS, 60: rows per screen.
- WORDS_PER_ROW, COLS/2 (40): memory words per row.

Ports:
- i_clk_25MHz  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  i_char/i_attr valid.
- o_ready  out  1  block can accept a byte this cycle.
- i_char  in  8  character code.
- i_attr  in  8  attribute: [7:4] bg color index, [3:0] fg color index.
- o_mem_we  out  4  byte write enables; 4'h0 = no write.
- o_mem_waddr  out  12  word address = row*WORDS_PER_ROW + col[6:1].
- o_mem_wdata  out  32  even col in [31:16] = {bg,fg,char}; odd col in [15:0] = {bg,fg,char}.
- o_cursor_col  out  7  current column, 0..COLS-1.
- o_cursor_row  out  6  current row, 0..ROWS-1.

Behaviour:
- Reset values:
  - o_mem_we=0, o_mem_waddr=0, o_mem_wdata=0.
  - cursor (0,0), state IDLE, o_ready=1.
- States:
  - IDLE: o_ready=1.
  - CLEAR_ROW: o_ready=0.
  - CLEAR_ALL: o_ready=0.
  - o_ready is a pure decode of the registered state.
- Accept:
  - A byte is accepted on a rising edge with i_valid & o_ready.
  - i_char and i_attr are sampled at acceptance; the attribute is latched into fill_attr.
- Memory outputs are registered: a write caused by acceptance at edge N is presented at N+1 for exactly one cycle. In every cycle without a write, o_mem_we=0.
- Printable byte (anything except 0x08, 0x0A, 0x0C, 0x0D; includes 0x00-0x1F others and 0x7F-0xFF):
  - Write at the cursor address.
    - col even: we=4'b1100, wdata={i_attr,i_char,16'h0}.
    - col odd: we=4'b0011, wdata={16'h0,i_attr,i_char}.
  - Then col+1.
  - If col was COLS-1: col=0, row advances (see line advance).
- 0x0D (CR): col=0, no write.
- 0x0A (LF): col=0, row advances (see line advance).
- 0x08 (BS):
  - col=0: no-op, no write, row unchanged.
  - col>0: col-1, and the new position is written with space (0x20) and i_attr, same byte-lane rules as a printable byte.
- 0x0C (FF): cursor to (0,0), enter CLEAR_ALL.
- Line advance:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Enter CLEAR_ROW for the new row. There is no hardware scroll; the display wraps to the top and the target row is blanked.
- CLEAR_ROW:
  - 12-bit counter k=0..WORDS_PER_ROW-1.
  - One write per cycle: we=4'hF, waddr=new_row*WORDS_PER_ROW+k, wdata={fill_attr,8'h20,fill_attr,8'h20}.
  - Return to IDLE after k=WORDS_PER_ROW-1.
  - o_ready low for exactly WORDS_PER_ROW cycles.
- Printable byte at col COLS-1: its char write occupies the acceptance+1 slot; the first clear write follows on the next cycle. Total o_ready low = 1+WORDS_PER_ROW cycles.
- CLEAR_ALL:
  - Same fill data; waddr=0..ROWS*WORDS_PER_ROW-1 (0..2399), one per cycle.
  - o_ready low for 2400 cycles.
- Cursor outputs update at the acceptance edge and are stable while clears run.
- i_valid while o_ready=0: ignored, no side effects; the upstream must hold the byte.
- Reset mid-clear: the clear is abandoned, o_mem_we drops to 0 immediately (asynchronously), and the block restarts in IDLE at (0,0). No partial-state recovery.
- Arithmetic: the address multiply is 6-bit row by constant 40, zero-extended to 12 bits. Max address is 2399; it never exceeds 12 bits.

Test Plan:
- After reset, accept 'A' with attr 0x1F → next cycle we=4'b1100, waddr=0, wdata=32'h1F41_0000; cursor (1,0); o_ready stays 1.
- Then accept 'B' attr 0x2E → we=4'b0011, waddr=0, wdata=32'h0000_2E42; cursor (2,0).
- At cursor (5,3), accept 0x0A attr 0x07 →
  - 40 consecutive writes with we=4'hF, waddr=160..199, wdata=32'h0720_0720.
  - o_ready low exactly 40 cycles; cursor (0,4).
- At cursor (79,59), accept 'Z' attr 0x1F →
  - write we=4'b0011, waddr=2399, wdata=32'h0000_1F5A.
  - Then the clear of row 0 (waddr 0..39); cursor (0,0).
- Backspace at (0,10) → no write, cursor unchanged. Backspace at (3,10) → write we=4'b1100, waddr=401, wdata[31:16]={attr,8'h20}; cursor (2,10).
- Accept 0x0C →
  - 2400 writes, waddr 0..2399, ready low for 2400 cycles.
  - Assert i_rst_n=0 at write 1000 → o_mem_we=0 at once.
  - After release: o_ready=1, cursor (0,0), and no further writes.
